// File: rtl/synth_pkg.sv
// Shared types and default widths for the synth voice datapath.
package synth_pkg;

    localparam int ACC_WIDTH_DEF = 24;
    localparam int D_WIDTH_DEF   = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } envStage_t;

endpackage

// File: rtl/env_velocity_scale.sv
// Registered velocity scaling of the envelope: (level * (velocity + 1)) >> 8.
module env_velocity_scale #(
    parameter int D_WIDTH = 16
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [D_WIDTH-1:0] level,
    input  logic [7:0]         velocity,
    output logic [D_WIDTH-1:0] scaled
);

    localparam int PW = D_WIDTH + 9;

    logic [PW-1:0] prod;

    // velocity + 1 spans 1..256, so full velocity passes the level through unchanged
    assign prod = PW'(level) * PW'({1'b0, velocity} + 9'd1);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            scaled <= '0;
        end else begin
            scaled <= D_WIDTH'(prod >> 8);
        end
    end

endmodule

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope generator stepped by the sample tick En.
// Define ADSR_VELOCITY_EN to add a velocity input that scales env (one extra cycle).
module adsr_envelope
    import synth_pkg::*;
#(
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int D_WIDTH   = D_WIDTH_DEF
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 En,
    input  logic                 Gate,
    input  logic [ACC_WIDTH-1:0] attackInc,
    input  logic [ACC_WIDTH-1:0] decayDec,
    input  logic [D_WIDTH-1:0]   sustainLvl,
    input  logic [ACC_WIDTH-1:0] releaseDec,
`ifdef ADSR_VELOCITY_EN
    input  logic [7:0]           velocity,
`endif
    output logic [D_WIDTH-1:0]   env,
    output logic                 active,
    output logic [2:0]           stage
);

    localparam logic [ACC_WIDTH-1:0] LVL_MAX = '1;

    envStage_t            st, st_nxt;
    logic [ACC_WIDTH-1:0] lvl, lvl_nxt;
    logic [ACC_WIDTH-1:0] target;
    logic                 gate_prev;
    logic                 rise, fall;
    logic [ACC_WIDTH:0]   att_sum, dec_diff, rel_diff;
    logic [D_WIDTH-1:0]   env_q;

    assign target   = ACC_WIDTH'(sustainLvl) << (ACC_WIDTH - D_WIDTH);
    assign rise     = Gate && !gate_prev;
    assign fall     = !Gate && gate_prev;
    // One guard bit: the top bit of a difference is the borrow, of the sum the carry
    assign att_sum  = {1'b0, lvl} + {1'b0, attackInc};
    assign dec_diff = {1'b0, lvl} - {1'b0, decayDec};
    assign rel_diff = {1'b0, lvl} - {1'b0, releaseDec};

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        lvl_nxt = lvl;
        st_nxt  = st;
        if (rise) begin
            st_nxt = ATTACK;
        end else if (fall && (st == ATTACK || st == DECAY || st == SUSTAIN)) begin
            st_nxt = RELEASE;
        end else begin
            case (st)
                IDLE: lvl_nxt = '0;
                ATTACK: begin
                    if (att_sum >= {1'b0, LVL_MAX} || attackInc == '0) begin
                        lvl_nxt = LVL_MAX;
                        st_nxt  = DECAY;
                    end else begin
                        lvl_nxt = att_sum[ACC_WIDTH-1:0];
                    end
                end
                DECAY: begin
                    // Also catches lvl already below target after a mid-decay sustain raise
                    if (decayDec == '0 || dec_diff[ACC_WIDTH] || dec_diff[ACC_WIDTH-1:0] <= target) begin
                        lvl_nxt = target;
                        st_nxt  = SUSTAIN;
                    end else begin
                        lvl_nxt = dec_diff[ACC_WIDTH-1:0];
                    end
                end
                SUSTAIN: lvl_nxt = target;
                RELEASE: begin
                    if (releaseDec == '0 || rel_diff[ACC_WIDTH] || rel_diff[ACC_WIDTH-1:0] == '0) begin
                        lvl_nxt = '0;
                        st_nxt  = IDLE;
                    end else begin
                        lvl_nxt = rel_diff[ACC_WIDTH-1:0];
                    end
                end
                default: begin
                    lvl_nxt = '0;
                    st_nxt  = IDLE;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample together.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            lvl       <= '0;
            st        <= IDLE;
            gate_prev <= 1'b0;
        end else if (En) begin
            lvl       <= lvl_nxt;
            st        <= st_nxt;
            gate_prev <= Gate;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            env_q  <= '0;
            active <= 1'b0;
            stage  <= 3'd0;
        end else begin
            env_q  <= lvl[ACC_WIDTH-1 -: D_WIDTH];
            active <= (st != IDLE);
            stage  <= st;
        end
    end

`ifdef ADSR_VELOCITY_EN
    logic [7:0] vel_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vel_q <= '0;
        end else if (En && rise) begin
            vel_q <= velocity;
        end
    end

    env_velocity_scale #(.D_WIDTH(D_WIDTH)) u_scale (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .level    (env_q),
        .velocity (vel_q),
        .scaled   (env)
    );
`else
    assign env = env_q;
`endif

endmodule

// File: tb/tb_adsr_envelope.sv
// Scoreboard bench for adsr_envelope: expected outputs queued per tick, compared after the tick.
module tb_adsr_envelope;

    logic        Clk = 1'b0;
    logic        Reset_n, En, Gate;
    logic [23:0] attackInc, decayDec, releaseDec;
    logic [15:0] sustainLvl;
    logic [15:0] env;
    logic        active;
    logic [2:0]  stage;
`ifdef ADSR_VELOCITY_EN
    logic [7:0]  velocity = 8'hFF;
`endif

    typedef struct {
        logic [15:0] env;
        logic [2:0]  stage;
        logic        active;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    adsr_envelope dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .En         (En),
        .Gate       (Gate),
        .attackInc  (attackInc),
        .decayDec   (decayDec),
        .sustainLvl (sustainLvl),
        .releaseDec (releaseDec),
`ifdef ADSR_VELOCITY_EN
        .velocity   (velocity),
`endif
        .env        (env),
        .active     (active),
        .stage      (stage)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One En tick every 4 clocks; outputs are sampled two falling edges after the tick.
    task automatic step(input string tag, input logic [15:0] e_env, input logic [2:0] e_st,
                        input logic e_act);
        exp_t e;
        sb.push_back('{env: e_env, stage: e_st, active: e_act});
        @(negedge Clk) En = 1'b1;
        @(negedge Clk) En = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        e = sb.pop_front();
        check({tag, ".env"},    32'(env),    32'(e.env));
        check({tag, ".stage"},  32'(stage),  32'(e.stage));
        check({tag, ".active"}, 32'(active), 32'(e.active));
    endtask

    initial begin
        logic [23:0] l;
        Reset_n    = 1'b0;
        En         = 1'b0;
        Gate       = 1'b0;
        attackInc  = 24'h100000;
        decayDec   = 24'h080000;
        sustainLvl = 16'h8000;
        releaseDec = 24'h200000;
        repeat (3) @(negedge Clk);
        check("reset.env", 32'(env), 32'h0);
        check("reset.stage", 32'(stage), 32'h0);
        check("reset.active", 32'(active), 32'h0);
        @(negedge Clk) Reset_n = 1'b1;

        // Attack from 0 in 0x100000 steps, saturating on the 16th increment
        Gate = 1'b1;
        step("gate_rise", 16'h0000, 3'd1, 1'b1);
        for (int k = 1; k <= 15; k++) step("attack", 16'(k * 16'h1000), 3'd1, 1'b1);
        step("attack_sat", 16'hFFFF, 3'd2, 1'b1);

        // Decay from full scale toward sustain 0x8000
        for (int k = 1; k <= 15; k++) begin
            l = 24'hFFFFFF - 24'(k) * 24'h080000;
            step("decay", l[23:8], 3'd2, 1'b1);
        end
        step("decay_snap", 16'h8000, 3'd3, 1'b1);
        sustainLvl = 16'h6000;
        step("sustain_track", 16'h6000, 3'd3, 1'b1);
        sustainLvl = 16'h8000;
        step("sustain_back", 16'h8000, 3'd3, 1'b1);

        // Release in 0x200000 steps down to idle
        Gate = 1'b0;
        step("gate_fall", 16'h8000, 3'd4, 1'b1);
        step("release1", 16'h6000, 3'd4, 1'b1);
        step("release2", 16'h4000, 3'd4, 1'b1);
        step("release3", 16'h2000, 3'd4, 1'b1);
        step("release_end", 16'h0000, 3'd0, 1'b0);

        // Zero attack/decay rates complete in one tick each; then retrigger mid-release
        attackInc = 24'h0;
        decayDec  = 24'h0;
        Gate = 1'b1;
        step("zr_rise", 16'h0000, 3'd1, 1'b1);
        step("zr_attack", 16'hFFFF, 3'd2, 1'b1);
        step("zr_decay", 16'h8000, 3'd3, 1'b1);
        Gate = 1'b0;
        step("rt_fall", 16'h8000, 3'd4, 1'b1);
        step("rt_rel1", 16'h6000, 3'd4, 1'b1);
        step("rt_rel2", 16'h4000, 3'd4, 1'b1);
        Gate = 1'b1;
        step("retrigger", 16'h4000, 3'd1, 1'b1);
        attackInc = 24'h100000;
        step("retrig_inc", 16'h5000, 3'd1, 1'b1);
        attackInc = 24'h0;
        step("rt_attack", 16'hFFFF, 3'd2, 1'b1);
        step("rt_decay", 16'h8000, 3'd3, 1'b1);
        releaseDec = 24'h0;
        Gate = 1'b0;
        step("zr_fall", 16'h8000, 3'd4, 1'b1);
        step("zr_release", 16'h0000, 3'd0, 1'b0);

        // Gate pulse entirely between two ticks is never seen
        @(negedge Clk) Gate = 1'b1;
        @(negedge Clk) Gate = 1'b0;
        step("short_pulse", 16'h0000, 3'd0, 1'b0);

        // Reach RELEASE at 0x400000, then assert reset between clock edges
        releaseDec = 24'h200000;
        Gate = 1'b1;
        step("mr_rise", 16'h0000, 3'd1, 1'b1);
        step("mr_attack", 16'hFFFF, 3'd2, 1'b1);
        step("mr_decay", 16'h8000, 3'd3, 1'b1);
        Gate = 1'b0;
        step("mr_fall", 16'h8000, 3'd4, 1'b1);
        step("mr_rel1", 16'h6000, 3'd4, 1'b1);
        step("mr_rel2", 16'h4000, 3'd4, 1'b1);
        Gate = 1'b1;
        @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        check("async_reset.env", 32'(env), 32'h0);
        check("async_reset.stage", 32'(stage), 32'h0);
        check("async_reset.active", 32'(active), 32'h0);
        @(negedge Clk) Reset_n = 1'b1;
        step("post_reset_rise", 16'h0000, 3'd1, 1'b1);

        check("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
